// File: rtl/alarm_buzzer_ctrl.sv
// alarm_buzzer_ctrl
//   Drives the piezo buzzer from the clock's alarm-match and hourly chime
//   events. Contains its own ms/second prescaler, a free-running tone
//   generator, debounced snooze/stop buttons and the ring/snooze/chime FSM.
//
// Ports
//   clk_50      in   board clock
//   ncr         in   synchronous reset, active-low
//   alarm_on    in   alarm armed (SwitchAL)
//   alarm_match in   high while alarm time equals clock time
//   chime_req   in   single-cycle pulse at the top of the hour
//   chime_hour  in   [4:0] hour to chime, binary 0..23
//   snooze_btn  in   raw asynchronous snooze button, active-high
//   stop_btn    in   raw asynchronous stop button, active-high
//   buzzer      out  gated tone to the piezo
//   ringing     out  high while ringing
//   snoozed     out  high while snoozing
//   chiming     out  high while chiming
module alarm_buzzer_ctrl #(
    parameter int CLK_HZ       = 50000000,
    parameter int TONE_HZ      = 2000,
    parameter int DEBOUNCE_MS  = 20,
    parameter int BEEP_ON_MS   = 250,
    parameter int BEEP_OFF_MS  = 250,
    parameter int CHIME_ON_MS  = 100,
    parameter int CHIME_OFF_MS = 200,
    parameter int RING_SEC     = 60,
    parameter int SNOOZE_SEC   = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clk_50,
    input  logic       ncr,
    input  logic       alarm_on,
    input  logic       alarm_match,
    input  logic       chime_req,
    input  logic [4:0] chime_hour,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozed,
    output logic       chiming
);

    localparam int MS_DIV    = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int TONE_HALF = (CLK_HZ / (2 * TONE_HZ) > 0) ? CLK_HZ / (2 * TONE_HZ) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RING   = 3'd1,
        SNOOZE = 3'd2,
        CHIME  = 3'd3,
        HOLD   = 3'd4
    } state_t;

    logic [31:0] msCnt_q, secCnt_q, toneCnt_q;
    logic        tone_q;
    logic        msTick, secTick, toneFlip;

    assign msTick   = (msCnt_q == 32'(MS_DIV - 1));
    assign secTick  = msTick && (secCnt_q == 32'd999);
    assign toneFlip = (toneCnt_q == 32'(TONE_HALF - 1));

    // Free-running timebase: a ms pulse, a second pulse built from 1000 ms
    // pulses, and the square-wave tone. None of these care about the FSM,
    // so the tone phase is independent of when a ring or chime starts.
    always_ff @(posedge clk_50) begin
        if (!ncr) begin
            msCnt_q   <= '0;
            secCnt_q  <= '0;
            toneCnt_q <= '0;
            tone_q    <= 1'b0;
        end else begin
            msCnt_q <= msTick ? '0 : msCnt_q + 32'd1;
            if (msTick) begin
                secCnt_q <= secTick ? '0 : secCnt_q + 32'd1;
            end
            toneCnt_q <= toneFlip ? '0 : toneCnt_q + 32'd1;
            if (toneFlip) begin
                tone_q <= ~tone_q;
            end
        end
    end

    // Index 0 is snooze, index 1 is stop.
    logic [1:0]  btnRaw, sync1_q, sync2_q, deb_q, debPrev_q, press;
    logic [31:0] dbCnt_q [2];
    logic        stopPress, snoozePress;

    assign btnRaw      = {stop_btn, snooze_btn};
    assign press       = deb_q & ~debPrev_q;
    assign stopPress   = press[1];
    assign snoozePress = press[0];

    // Button conditioning: two-flop synchronizer, then a debouncer that
    // samples once per ms and only adopts the synchronized level after it
    // has differed from the accepted level for DEBOUNCE_MS samples in a row.
    // Any sample that agrees with the accepted level restarts the count, so
    // short glitches never get through. A press is the rising edge of the
    // accepted level.
    always_ff @(posedge clk_50) begin
        if (!ncr) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            debPrev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btnRaw;
            sync2_q   <= sync1_q;
            debPrev_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                if (msTick) begin
                    if (sync2_q[i] == deb_q[i]) begin
                        dbCnt_q[i] <= '0;
                    end else if (dbCnt_q[i] == 32'(DEBOUNCE_MS - 1)) begin
                        deb_q[i]   <= sync2_q[i];
                        dbCnt_q[i] <= '0;
                    end else begin
                        dbCnt_q[i] <= dbCnt_q[i] + 32'd1;
                    end
                end
            end
        end
    end

    logic armed, armPrev_q, started_q, alarmEvt_q;

    assign armed = alarm_on & alarm_match;

    // Alarm event detector: registered rising edge of the armed match.
    // started_q masks the first cycle after reset so that a match which was
    // already high through reset is not mistaken for a fresh edge.
    always_ff @(posedge clk_50) begin
        if (!ncr) begin
            started_q  <= 1'b0;
            armPrev_q  <= 1'b0;
            alarmEvt_q <= 1'b0;
        end else begin
            started_q  <= 1'b1;
            armPrev_q  <= armed;
            alarmEvt_q <= started_q & armed & ~armPrev_q;
        end
    end

    logic [3:0] hourMod, chimeBeeps;

    // Beep count for the chime: hour modulo 12, with 0 becoming 12.
    always_comb begin
        hourMod = chime_hour[3:0];
        if (chime_hour >= 5'd24) begin
            hourMod = 4'(chime_hour - 5'd24);
        end else if (chime_hour >= 5'd12) begin
            hourMod = 4'(chime_hour - 5'd12);
        end
        chimeBeeps = (hourMod == 4'd0) ? 4'd12 : hourMod;
    end

    state_t      state_q, state_d;
    logic [31:0] phaseCnt_q, phaseCnt_d, ringSec_q, ringSec_d;
    logic [31:0] snzSec_q, snzSec_d, snoozeCnt_q, snoozeCnt_d;
    logic [3:0]  beeps_q, beeps_d;
    logic        phaseOn_q, phaseOn_d, gate;
    logic        buzzer_q, ringing_q, snoozed_q, chiming_q;

    // Next-state and timer logic. RING and CHIME share one ms phase counter
    // and on/off flag for their cadences. Whenever the state changes, all
    // sub-state timers are cleared and the cadence restarts on its on-phase,
    // so every RING or CHIME entry begins with sound.
    always_comb begin
        state_d     = state_q;
        phaseCnt_d  = phaseCnt_q;
        phaseOn_d   = phaseOn_q;
        ringSec_d   = ringSec_q;
        snzSec_d    = snzSec_q;
        snoozeCnt_d = snoozeCnt_q;
        beeps_d     = beeps_q;
        gate        = 1'b0;
        case (state_q)
            IDLE: begin
                if (alarmEvt_q) begin
                    state_d     = RING;
                    snoozeCnt_d = '0;
                end else if (chime_req) begin
                    state_d = CHIME;
                    beeps_d = chimeBeeps;
                end
            end
            RING: begin
                gate = phaseOn_q;
                if (msTick) begin
                    if (phaseCnt_q == (phaseOn_q ? 32'(BEEP_ON_MS - 1) : 32'(BEEP_OFF_MS - 1))) begin
                        phaseCnt_d = '0;
                        phaseOn_d  = ~phaseOn_q;
                    end else begin
                        phaseCnt_d = phaseCnt_q + 32'd1;
                    end
                end
                if (secTick) begin
                    ringSec_d = ringSec_q + 32'd1;
                end
                if (!alarm_on) begin
                    state_d = IDLE;
                end else if (stopPress) begin
                    state_d = HOLD;
                end else if (snoozePress) begin
                    if (snoozeCnt_q < 32'(MAX_SNOOZE)) begin
                        state_d     = SNOOZE;
                        snoozeCnt_d = snoozeCnt_q + 32'd1;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (secTick && ringSec_q == 32'(RING_SEC - 1)) begin
                    state_d = HOLD;
                end
            end
            SNOOZE: begin
                if (secTick) begin
                    snzSec_d = snzSec_q + 32'd1;
                end
                if (!alarm_on || stopPress) begin
                    state_d = IDLE;
                end else if (secTick && snzSec_q == 32'(SNOOZE_SEC - 1)) begin
                    state_d = RING;
                end
            end
            CHIME: begin
                gate = phaseOn_q;
                if (alarmEvt_q) begin
                    state_d     = RING;
                    snoozeCnt_d = '0;
                end else if (msTick) begin
                    if (phaseOn_q) begin
                        if (phaseCnt_q == 32'(CHIME_ON_MS - 1)) begin
                            phaseCnt_d = '0;
                            phaseOn_d  = 1'b0;
                        end else begin
                            phaseCnt_d = phaseCnt_q + 32'd1;
                        end
                    end else if (phaseCnt_q == 32'(CHIME_OFF_MS - 1)) begin
                        if (beeps_q <= 4'd1) begin
                            state_d = IDLE;
                        end else begin
                            beeps_d    = beeps_q - 4'd1;
                            phaseCnt_d = '0;
                            phaseOn_d  = 1'b1;
                        end
                    end else begin
                        phaseCnt_d = phaseCnt_q + 32'd1;
                    end
                end
            end
            HOLD: begin
                if (!alarm_on || !alarm_match) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            phaseCnt_d = '0;
            phaseOn_d  = 1'b1;
            ringSec_d  = '0;
            snzSec_d   = '0;
        end
    end

    // State and timer registers, plus the registered buzzer and status
    // outputs. The buzzer follows the gate one cycle late, and the status
    // flags are decodes of the current state, also one cycle late.
    always_ff @(posedge clk_50) begin
        if (!ncr) begin
            state_q     <= IDLE;
            phaseCnt_q  <= '0;
            phaseOn_q   <= 1'b0;
            ringSec_q   <= '0;
            snzSec_q    <= '0;
            snoozeCnt_q <= '0;
            beeps_q     <= '0;
            buzzer_q    <= 1'b0;
            ringing_q   <= 1'b0;
            snoozed_q   <= 1'b0;
            chiming_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phaseCnt_q  <= phaseCnt_d;
            phaseOn_q   <= phaseOn_d;
            ringSec_q   <= ringSec_d;
            snzSec_q    <= snzSec_d;
            snoozeCnt_q <= snoozeCnt_d;
            beeps_q     <= beeps_d;
            buzzer_q    <= tone_q & gate;
            ringing_q   <= (state_q == RING);
            snoozed_q   <= (state_q == SNOOZE);
            chiming_q   <= (state_q == CHIME);
        end
    end

    assign buzzer  = buzzer_q;
    assign ringing = ringing_q;
    assign snoozed = snoozed_q;
    assign chiming = chiming_q;

endmodule
